bcd_disp_mux: RTL and testbench

//  Time-multiplexed 7-segment driver for a multi-digit BCD value, placed directly downstream of
//  the chained single-digit BCD incrementors. Captures the packed BCD word on a load strobe and

---
 rtl/bcd_disp_mux.sv | 127 ++++++++++++
 tb/tb_bcd_disp_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_disp_mux.sv
// Time-multiplexed 7-segment driver for a packed BCD word.
// It shows one digit at a time, with active-low anodes and segments and leading-zero blanking.
module bcd_disp_mux #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic                    frame_done
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PCNT = PW'(DIGIT_CYCLES - 1);

  logic [4*N_DIGITS-1:0] shadow_bcd_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [IW-1:0]         idx_r;
  logic [PW-1:0]         pcnt_r;
  logic                  wrap_r;
  logic [N_DIGITS-1:0]   an_r;
  logic [7:0]            sseg_r;
  logic                  frame_done_r;

  logic [N_DIGITS-1:0]   blank_s;
  logic                  zero_above_s;
  logic                  digit_zero_s;
  logic [3:0]            digit_s;
  logic [6:0]            seg_next_s;
  logic [N_DIGITS-1:0]   an_next_s;
  logic                  scan_step_s;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // A digit is blanked only while every more significant digit is zero; an invalid code ends the run.
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    digit_zero_s = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      digit_zero_s = (shadow_bcd_r[4*k +: 4] == 4'd0);
      if (k != 0) begin
        blank_s[k] = blank_lz & zero_above_s & digit_zero_s;
      end else begin
        blank_s[k] = 1'b0;
      end
      zero_above_s = zero_above_s & digit_zero_s;
    end
  end

  // Next-cycle digit, segment and anode values for the digit currently selected.
  always_comb begin
    digit_s   = shadow_bcd_r[{idx_r, 2'b00} +: 4];
    an_next_s = '1;
    an_next_s[idx_r] = 1'b0;
    if (blank_s[idx_r]) begin
      seg_next_s = 7'h7F;
    end else begin
      seg_next_s = seg_decode(digit_s);
    end
  end

  assign scan_step_s = (pcnt_r == LAST_PCNT);

  // Shadow capture, scan counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_bcd_r <= '0;
      shadow_dp_r  <= '0;
      idx_r        <= '0;
      pcnt_r       <= '0;
      wrap_r       <= 1'b0;
      an_r         <= '1;
      sseg_r       <= 8'hFF;
      frame_done_r <= 1'b0;
    end else begin
      if (load) begin
        shadow_bcd_r <= bcd_in;
        shadow_dp_r  <= dp_in;
      end else begin
        shadow_bcd_r <= shadow_bcd_r;
        shadow_dp_r  <= shadow_dp_r;
      end
      if (scan_step_s) begin
        pcnt_r <= '0;
        idx_r  <= (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
        idx_r  <= idx_r;
      end
      // Delayed one extra cycle so the pulse lines up with digit 0 reappearing on the anodes.
      wrap_r       <= scan_step_s & (idx_r == LAST_IDX);
      frame_done_r <= wrap_r;
      an_r         <= an_next_s;
      sseg_r       <= {~shadow_dp_r[idx_r], seg_next_s};
    end
  end

  assign an         = an_r;
  assign sseg       = sseg_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed bench for bcd_disp_mux with N_DIGITS=4 and DIGIT_CYCLES=4.
// It uses table-driven full-frame checks plus hand-timed multi-cycle sequences.
module tb_bcd_disp_mux;

  localparam int ND = 4;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] exp_seg;   // index = digit number
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  bcd_disp_mux #(.N_DIGITS(ND), .DIGIT_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .an(an), .sseg(sseg), .frame_done(frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reset for one edge, then load on the first edge after release (edge E1); returns after E1.
  task automatic restart(input logic [15:0] b, input logic [3:0] d, input logic blz);
    reset_n = 1'b0; load = 1'b0;
    step();
    reset_n = 1'b1; load = 1'b1; bcd_in = b; dp_in = d; blank_lz = blz;
    step();
    load = 1'b0;
  endtask

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][7:0] seq1234;
    logic [3:0]      exp_an;
    int              d;

    vecs[0] = '{bcd:16'h1234, dp:4'b0000, blz:1'b0, exp_seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{bcd:16'h0050, dp:4'b0000, blz:1'b1, exp_seg:{8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[2] = '{bcd:16'h0000, dp:4'b0000, blz:1'b1, exp_seg:{8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{bcd:16'h0000, dp:4'b0000, blz:1'b0, exp_seg:{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[4] = '{bcd:16'h0A09, dp:4'b0001, blz:1'b1, exp_seg:{8'hFF, 8'hBF, 8'hC0, 8'h10}};
    vecs[5] = '{bcd:16'h9876, dp:4'b1010, blz:1'b0, exp_seg:{8'h10, 8'h80, 8'h78, 8'h82}};
    vecs[6] = '{bcd:16'h0F00, dp:4'b0100, blz:1'b1, exp_seg:{8'hFF, 8'h3F, 8'hC0, 8'hC0}};
    vecs[7] = '{bcd:16'h0001, dp:4'b1000, blz:1'b1, exp_seg:{8'h7F, 8'hFF, 8'hFF, 8'hF9}};
    seq1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};

    // 1. Reset held with load active.
    reset_n = 1'b0; load = 1'b1; bcd_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_an", 16'(an), 16'hF);
      chk("reset_sseg", 16'(sseg), 16'hFF);
      chk("reset_fd", 16'(frame_done), 16'h0);
    end

    // 2. Exact scan timing and frame_done placement for 16'h1234.
    restart(16'h1234, 4'b0000, 1'b0);
    chk("e1_an", 16'(an), 16'hE);
    chk("e1_sseg_old_shadow", 16'(sseg), 16'hC0);
    chk("e1_fd", 16'(frame_done), 16'h0);
    for (int k = 2; k <= 33; k++) begin
      step();
      d = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << d);
      chk("scan_an", 16'(an), 16'(exp_an));
      chk("scan_sseg", 16'(sseg), 16'(seq1234[d]));
      chk("scan_fd", 16'(frame_done), (k == 17 || k == 33) ? 16'h1 : 16'h0);
    end

    // Table: one full frame per vector, sseg checked against the digit the anode selects.
    for (int i = 0; i < 8; i++) begin
      restart(vecs[i].bcd, vecs[i].dp, vecs[i].blz);
      step();
      for (int c = 0; c < 16; c++) begin
        d = an_to_idx(an);
        if (d < 0) begin
          chk("tbl_an_onehot", 16'(an), 16'hE);
        end else begin
          chk($sformatf("tbl%0d_d%0d", i, d), 16'(sseg), 16'(vecs[i].exp_seg[d]));
        end
        step();
      end
    end

    // 3. blank_lz change shows on the very next output update.
    restart(16'h0000, 4'b0000, 1'b1);
    for (int k = 2; k <= 9; k++) step();
    chk("blz_an", 16'(an), 16'hB);
    chk("blz_on", 16'(sseg), 16'hFF);
    blank_lz = 1'b0;
    step();
    chk("blz_off", 16'(sseg), 16'hC0);

    // 5. Glitch immunity while load=0, then a load coincident with the idx advance.
    restart(16'h1234, 4'b0000, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      bcd_in = 16'($urandom());
      step();
      chk("glitch_sseg", 16'(sseg), (k <= 4) ? 16'h99 : 16'hB0);
    end
    load = 1'b1; bcd_in = 16'h5678;
    step();
    chk("ld_edge_an", 16'(an), 16'hD);
    chk("ld_edge_sseg", 16'(sseg), 16'hB0);
    load = 1'b0; bcd_in = 16'($urandom());
    step();
    chk("ld_next_an", 16'(an), 16'hB);
    chk("ld_next_sseg", 16'(sseg), 16'h82);
    step();
    chk("ld_hold_sseg", 16'(sseg), 16'h82);

    // 6. Mid-scan reset while digit 2 is displayed.
    restart(16'h1234, 4'b0000, 1'b0);
    for (int k = 2; k <= 9; k++) step();
    chk("mid_pre_an", 16'(an), 16'hB);
    reset_n = 1'b0; load = 1'b1; bcd_in = 16'h9999;
    step();
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_sseg", 16'(sseg), 16'hFF);
    chk("mid_rst_fd", 16'(frame_done), 16'h0);
    reset_n = 1'b1; load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("mid_restart_an", 16'(an), (k <= 4) ? 16'hE : 16'hD);
      chk("mid_restart_sseg", 16'(sseg), 16'hC0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
